// File: rtl/spi_temp_reader_pkg.sv
// Shared state encoding and default timing constants for the SPI temperature reader.
package spi_temp_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_e;

   localparam int DEF_CLK_DIV    = 25;
   localparam int DEF_FRAME_BITS = 16;
   localparam int DEF_CS_SETUP   = 2;
   localparam int DEF_CS_HOLD    = 2;
   localparam int DEF_CS_IDLE    = 4;

   // Width of one counter shared by the SETUP, HOLD and GAP phases.
   function automatic int phase_cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/spi_temp_reader_sclk_divider.sv
// SCLK half-period timer: while enabled, emits alternating rise/fall strobes every CLK_DIV cycles,
// starting from the low phase. Disabling it clears the count and phase.
module sclk_divider
   import spi_temp_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_rise,
   output logic o_fall
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_cnt;
   logic             r_phase;
   logic             w_term;

   assign w_term = i_en && (r_cnt == TERM);
   assign o_rise = w_term && !r_phase;
   assign o_fall = w_term && r_phase;

   // Half-period count and current SCLK phase (0 = low).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (!i_en) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (w_term) begin
         r_cnt   <= '0;
         r_phase <= !r_phase;
      end else begin
         r_cnt   <= r_cnt + DIV_W'(1);
         r_phase <= r_phase;
      end
   end

endmodule

// File: rtl/spi_temp_reader.sv
// Read-only SPI mode-0 master: one FRAME_BITS word per accepted start, MSB first on MISO,
// result published with a one-cycle valid pulse at the moment chip select is released.
module spi_temp_reader
   import spi_temp_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int CS_SETUP   = DEF_CS_SETUP,
   parameter int CS_HOLD    = DEF_CS_HOLD,
   parameter int CS_IDLE    = DEF_CS_IDLE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  spi_miso,
   output logic                  spi_sclk,
   output logic                  spi_cs_n,
   output logic [FRAME_BITS-1:0] temp_data,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam logic [2:0] ST_IDLE  = S_IDLE;
   localparam logic [2:0] ST_SETUP = S_SETUP;
   localparam logic [2:0] ST_SHIFT = S_SHIFT;
   localparam logic [2:0] ST_HOLD  = S_HOLD;
   localparam logic [2:0] ST_GAP   = S_GAP;

   localparam int CNT_W = phase_cnt_width(CS_SETUP, CS_HOLD, CS_IDLE);
   localparam int BIT_W = $clog2(FRAME_BITS + 1);

   // The IDLE cycle that accepts the next start also has cs_n high, so GAP is one cycle
   // shorter than the required high time; with CS_IDLE = 1 HOLD returns straight to IDLE.
   localparam int         GAP_CYC   = (CS_IDLE > 1) ? CS_IDLE - 1 : 1;
   localparam logic [2:0] HOLD_EXIT = (CS_IDLE > 1) ? ST_GAP : ST_IDLE;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);

   logic [2:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_sclk;
   logic                  r_cs_n;
   logic [FRAME_BITS-1:0] r_temp;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_overrun;

   logic [2:0]            w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [BIT_W-1:0]      w_bit_nxt;
   logic [FRAME_BITS-1:0] w_shift_nxt;
   logic                  w_load;
   logic                  w_sclk_nxt;
   logic                  w_div_en;
   logic                  w_rise;
   logic                  w_fall;

   assign w_div_en = (r_state == ST_SHIFT);

   sclk_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_divider (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_div_en),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // Frame sequencing: next state, phase/bit counters and the receive shift register.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_shift_nxt = {FRAME_BITS{1'b0}};
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (r_cnt == SETUP_LAST) begin
               w_state_nxt = ST_SHIFT;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_SHIFT: begin
            // Sample on the clk edge that raises SCLK; the sensor changes data on the fall.
            if (w_rise) begin
               w_shift_nxt = {r_shift[FRAME_BITS-2:0], spi_miso};
            end else begin
               w_shift_nxt = r_shift;
            end
            if (w_fall) begin
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_nxt = ST_HOLD;
                  w_bit_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_bit_nxt = r_bit_cnt + BIT_W'(1);
               end
            end else begin
               w_bit_nxt = r_bit_cnt;
            end
         end
         ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nxt = HOLD_EXIT;
               w_cnt_nxt   = '0;
               w_load      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = {FRAME_BITS{1'b0}};
         end
      endcase
   end

   // SCLK level following the divider strobes.
   always_comb begin
      if (w_rise) begin
         w_sclk_nxt = 1'b1;
      end else if (w_fall) begin
         w_sclk_nxt = 1'b0;
      end else begin
         w_sclk_nxt = r_sclk;
      end
   end

   // State and registered outputs; SCLK is forced low outside SHIFT so it never runs with cs_n high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= {FRAME_BITS{1'b0}};
         r_sclk    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_temp    <= {FRAME_BITS{1'b0}};
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_sclk    <= (w_state_nxt == ST_SHIFT) ? w_sclk_nxt : 1'b0;
         r_cs_n    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP);
         r_temp    <= w_load ? r_shift : r_temp;
         r_valid   <= w_load;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_overrun <= start && (r_state != ST_IDLE);
      end
   end

   assign spi_sclk   = r_sclk;
   assign spi_cs_n   = r_cs_n;
   assign temp_data  = r_temp;
   assign data_valid = r_valid;
   assign busy       = r_busy;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Directed + randomized bench for spi_temp_reader with a falling-edge-shifting sensor model.
module tb_spi_temp_reader;

   localparam int CLK_DIV    = 4;
   localparam int FRAME_BITS = 16;
   localparam int CS_SETUP   = 2;
   localparam int CS_HOLD    = 2;
   localparam int CS_IDLE    = 4;
   localparam int CS_LOW     = CS_SETUP + 2 * FRAME_BITS * CLK_DIV + CS_HOLD;
   localparam int LATENCY    = 1 + CS_LOW;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic                  spi_miso;
   logic                  spi_sclk;
   logic                  spi_cs_n;
   logic [FRAME_BITS-1:0] temp_data;
   logic                  data_valid;
   logic                  busy;
   logic                  overrun;

   int vectors     = 0;
   int miscompares = 0;

   spi_temp_reader #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS),
      .CS_SETUP   (CS_SETUP),
      .CS_HOLD    (CS_HOLD),
      .CS_IDLE    (CS_IDLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .spi_miso   (spi_miso),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .temp_data  (temp_data),
      .data_valid (data_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Sensor: MSB presented when selected, next bit after every SCLK fall.
   logic [FRAME_BITS-1:0] sens_word = '0;
   int                    fall_cnt  = 0;
   always @(negedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n) fall_cnt = 0;
      else          fall_cnt = fall_cnt + 1;
   end
   assign spi_miso = (fall_cnt < FRAME_BITS) ? sens_word[FRAME_BITS-1-fall_cnt] : 1'b0;

   // Bus observer sampled on the inactive clock edge.
   int   valid_cnt = 0, rise_cnt = 0, glitch_cnt = 0;
   int   hi_run = 0, lo_run = 0, last_hi_run = 0, last_lo_run = 0;
   logic prev_sclk = 1'b0;
   always @(negedge clk) begin
      if (data_valid) valid_cnt++;
      if (spi_sclk && !prev_sclk) rise_cnt++;
      prev_sclk = spi_sclk;
      if (spi_sclk && spi_cs_n) glitch_cnt++;
      if (spi_cs_n) begin
         if (lo_run > 0) begin last_lo_run = lo_run; lo_run = 0; end
         hi_run++;
      end else begin
         if (hi_run > 0) begin last_hi_run = hi_run; hi_run = 0; end
         lo_run++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 400) begin @(negedge clk); n++; end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input logic [FRAME_BITS-1:0] w);
      int v0, r0, n;
      sens_word = w;
      v0 = valid_cnt;
      r0 = rise_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 1;
      while (!data_valid && n < 400) begin @(negedge clk); n++; end
      check("valid_latency", n, LATENCY);
      check("temp_data", 32'(temp_data), 32'(w));
      check("cs_n_rises_with_valid", 32'(spi_cs_n), 32'd1);
      @(negedge clk);
      check("valid_one_cycle", 32'(data_valid), 32'd0);
      wait_idle("frame_busy_drop");
      @(negedge clk);
      check("sclk_rises", rise_cnt - r0, FRAME_BITS);
      check("cs_low_cycles", last_lo_run, CS_LOW);
      check("valid_pulses", valid_cnt - v0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, r0, n, viol;
      logic [FRAME_BITS-1:0] w;

      repeat (3) @(negedge clk);
      check("rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("rst_sclk", 32'(spi_sclk), 32'd0);
      check("rst_temp", 32'(temp_data), 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      run_frame(16'h1A5C);
      run_frame(16'h0000);
      repeat (20) @(negedge clk);
      run_frame(16'hFFFF);
      check("no_sclk_with_cs_high", glitch_cnt, 0);

      for (int k = 0; k < 4; k++) begin
         w = FRAME_BITS'($urandom);
         repeat ($urandom_range(1, 30)) @(negedge clk);
         run_frame(w);
      end

      // Start request landing mid-frame is dropped with an overrun pulse.
      w = FRAME_BITS'($urandom);
      sens_word = w;
      v0 = valid_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      repeat (48) @(negedge clk);
      check("overrun_quiet", 32'(overrun), 32'd0);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("overrun_pulse", 32'(overrun), 32'd1);
      @(negedge clk);
      check("overrun_one_cycle", 32'(overrun), 32'd0);
      wait_idle("overrun_busy_drop");
      check("overrun_frame_data", 32'(temp_data), 32'(w));
      repeat (30) @(negedge clk);
      check("overrun_single_valid", valid_cnt - v0, 1);
      check("overrun_single_frame_cs", 32'(spi_cs_n), 32'd1);

      // Start held high: back-to-back frames with the minimum chip-select gap.
      w = FRAME_BITS'($urandom);
      sens_word = w;
      v0 = valid_cnt;
      @(negedge clk) start = 1'b1;
      repeat (400) @(negedge clk);
      start = 1'b0;
      check("held_valid_count", valid_cnt - v0, 2);
      check("held_cs_gap", last_hi_run, CS_IDLE);
      check("held_temp", 32'(temp_data), 32'(w));
      wait_idle("held_busy_drop");
      check("held_no_glitch", glitch_cnt, 0);

      // Reset in the middle of a frame.
      repeat (10) @(negedge clk);
      sens_word = FRAME_BITS'($urandom);
      r0 = rise_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while ((rise_cnt - r0) < 7 && n < 200) begin @(negedge clk); n++; end
      check("pre_rst_sclk_high", 32'(spi_sclk), 32'd1);
      v0 = valid_cnt;
      rst = 1'b1;
      #1;
      check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
      check("midrst_sclk", 32'(spi_sclk), 32'd0);
      check("midrst_temp", 32'(temp_data), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      check("midrst_no_valid", valid_cnt - v0, 0);
      check("midrst_temp_kept", 32'(temp_data), 32'd0);
      run_frame(16'h1A5C);

      // Idle with no requests.
      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0) viol++;
      end
      check("idle_quiet", viol, 0);
      check("final_no_glitch", glitch_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
